// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared definitions for the RV32I decode stage.
//   - OPC_* : major opcodes (instr[6:0]) recognised by the decoder
//   - F7_*  : funct7 values that distinguish OP / shift variants
//   - sys_op_e : encoding of the ECALL/EBREAK indication
//   - decoded_t : the per-instruction bundle held in each pipeline entry
package rv_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        SYS_NONE   = 2'b00,
        SYS_ECALL  = 2'b01,
        SYS_EBREAK = 2'b10
    } sys_op_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  zimm;
        logic        shift_la_sel;
        logic [7:0]  pred_succ;
        sys_op_e     sys_op;
        logic        trap;
    } decoded_t;

endpackage

// File: rtl/rv_decode_stage_if.sv
// rv_decode_stage_if: handshake and decoded-output bundle of the decode stage.
//   Upstream : in_valid, in_ready, in_pc, in_instr
//   Downstream: out_valid, out_ready, pc, opcode, funct3, funct7, rd, rs1, rs2,
//               imm, zimm, shift_la_sel, pred_succ, sys_op, trap
//   slave  : the decode stage side
//   master : the environment side (fetch feeding in, execute consuming out)
interface rv_decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [4:0]      zimm;
    logic            shift_la_sel;
    logic [7:0]      pred_succ;
    logic [1:0]      sys_op;
    logic            trap;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, pc, opcode, funct3, funct7, rd, rs1, rs2,
               imm, zimm, shift_la_sel, pred_succ, sys_op, trap
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, pc, opcode, funct3, funct7, rd, rs1, rs2,
               imm, zimm, shift_la_sel, pred_succ, sys_op, trap
    );
endinterface

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: purely combinational RV32I(+M, +Zicsr) instruction decoder.
//   instr_i : 32-bit instruction word
//   dec_o   : decoded bundle; fields not used by the format are 0, trap flags
//             illegal, reserved or disabled encodings
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter bit ENABLE_M     = 1'b1,
    parameter bit ENABLE_ZICSR = 1'b1
) (
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic [31:0] imm_csr_s;

    assign funct3_s  = instr_i[14:12];
    assign funct7_s  = instr_i[31:25];
    assign imm_i_s   = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_s   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_s   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_s   = {instr_i[31:12], 12'h000};
    assign imm_j_s   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_csr_s = {20'h00000, instr_i[31:20]};

    // Field selection and legality per major opcode.
    always_comb begin
        dec_o        = '0;
        dec_o.opcode = instr_i[6:0];
        dec_o.funct3 = funct3_s;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_o.funct3 = 3'b000;
                dec_o.rd     = instr_i[11:7];
                dec_o.imm    = imm_u_s;
            end
            OPC_JAL: begin
                dec_o.funct3 = 3'b000;
                dec_o.rd     = instr_i[11:7];
                dec_o.imm    = imm_j_s;
            end
            OPC_JALR: begin
                dec_o.rd   = instr_i[11:7];
                dec_o.rs1  = instr_i[19:15];
                dec_o.imm  = imm_i_s;
                dec_o.trap = (funct3_s != 3'b000);
            end
            OPC_BRANCH: begin
                dec_o.rs1  = instr_i[19:15];
                dec_o.rs2  = instr_i[24:20];
                dec_o.imm  = imm_b_s;
                dec_o.trap = (funct3_s[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec_o.rd   = instr_i[11:7];
                dec_o.rs1  = instr_i[19:15];
                dec_o.imm  = imm_i_s;
                dec_o.trap = (funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_o.rs1  = instr_i[19:15];
                dec_o.rs2  = instr_i[24:20];
                dec_o.imm  = imm_s_s;
                dec_o.trap = (funct3_s > 3'b010);
            end
            OPC_OPIMM: begin
                dec_o.rd  = instr_i[11:7];
                dec_o.rs1 = instr_i[19:15];
                dec_o.imm = imm_i_s;
                // Shift-immediates carry funct7 in the upper immediate bits.
                case (funct3_s)
                    3'b001: begin
                        dec_o.funct7 = funct7_s;
                        dec_o.trap   = (funct7_s != F7_BASE);
                    end
                    3'b101: begin
                        dec_o.funct7       = funct7_s;
                        dec_o.shift_la_sel = instr_i[30];
                        dec_o.trap         = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
                    end
                    default: begin
                        dec_o.funct7 = 7'b0000000;
                    end
                endcase
            end
            OPC_OP: begin
                dec_o.rd     = instr_i[11:7];
                dec_o.rs1    = instr_i[19:15];
                dec_o.rs2    = instr_i[24:20];
                dec_o.funct7 = funct7_s;
                case (funct7_s)
                    F7_BASE: begin
                        dec_o.trap = 1'b0;
                    end
                    F7_ALT: begin
                        dec_o.shift_la_sel = 1'b1;
                        dec_o.trap         = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
                    end
                    F7_MULDIV: begin
                        dec_o.trap = !ENABLE_M;
                    end
                    default: begin
                        dec_o.trap = 1'b1;
                    end
                endcase
            end
            OPC_FENCE: begin
                dec_o.rd        = instr_i[11:7];
                dec_o.rs1       = instr_i[19:15];
                dec_o.imm       = imm_i_s;
                dec_o.pred_succ = instr_i[27:20];
            end
            OPC_SYSTEM: begin
                case (funct3_s)
                    3'b000: begin
                        // Only the two exact privileged encodings are accepted.
                        if (instr_i == INSTR_ECALL) begin
                            dec_o.sys_op = SYS_ECALL;
                        end else if (instr_i == INSTR_EBREAK) begin
                            dec_o.sys_op = SYS_EBREAK;
                        end else begin
                            dec_o.trap = 1'b1;
                        end
                    end
                    3'b100: begin
                        dec_o.trap = 1'b1;
                    end
                    default: begin
                        // CSR forms: funct3[2] selects the 5-bit immediate source.
                        dec_o.rd  = instr_i[11:7];
                        dec_o.imm = imm_csr_s;
                        if (funct3_s[2]) begin
                            dec_o.zimm = instr_i[19:15];
                        end else begin
                            dec_o.rs1 = instr_i[19:15];
                        end
                        dec_o.trap = !ENABLE_ZICSR;
                    end
                endcase
            end
            default: begin
                dec_o.trap = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decode stage with a two-entry skid buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous discard of both entries (drops a same-cycle accept)
//   bus        : rv_decode_stage_if.slave -- upstream valid/ready with pc/instr,
//                downstream valid/ready with the decoded fields of entry 'main'
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter bit ENABLE_M     = 1'b1,
    parameter bit ENABLE_ZICSR = 1'b1,
    parameter int PC_W         = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    rv_decode_stage_if.slave   bus
);

    decoded_t        dec_s;
    logic            accept_s;
    logic            consume_s;

    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [PC_W-1:0] main_pc_q, main_pc_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    decoded_t        main_dec_q, main_dec_d;
    decoded_t        skid_dec_q, skid_dec_d;

    rv_decode_comb #(
        .ENABLE_M     (ENABLE_M),
        .ENABLE_ZICSR (ENABLE_ZICSR)
    ) u_dec (
        .instr_i (bus.in_instr),
        .dec_o   (dec_s)
    );

    assign accept_s  = bus.in_valid && !skid_valid_q;
    assign consume_s = main_valid_q && bus.out_ready;

    // Entry update: flush first, then skid drains into main, then accept.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_pc_d    = main_pc_q;
        main_dec_d   = main_dec_q;
        skid_pc_d    = skid_pc_q;
        skid_dec_d   = skid_dec_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so no accept can coincide with the drain.
            if (consume_s) begin
                main_pc_d    = skid_pc_q;
                main_dec_d   = skid_dec_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = main_valid_q;
            end
        end else if (accept_s) begin
            if (!main_valid_q || consume_s) begin
                main_valid_d = 1'b1;
                main_pc_d    = bus.in_pc;
                main_dec_d   = dec_s;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = bus.in_pc;
                skid_dec_d   = dec_s;
            end
        end else if (consume_s) begin
            main_valid_d = 1'b0;
        end else begin
            main_valid_d = main_valid_q;
        end
    end

    // Entry registers; reset clears valids and payloads so outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_pc_q    <= '0;
            skid_pc_q    <= '0;
            main_dec_q   <= '0;
            skid_dec_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_pc_q    <= main_pc_d;
            skid_pc_q    <= skid_pc_d;
            main_dec_q   <= main_dec_d;
            skid_dec_q   <= skid_dec_d;
        end
    end

    assign bus.in_ready     = !skid_valid_q;
    assign bus.out_valid    = main_valid_q;
    assign bus.pc           = main_pc_q;
    assign bus.opcode       = main_dec_q.opcode;
    assign bus.funct3       = main_dec_q.funct3;
    assign bus.funct7       = main_dec_q.funct7;
    assign bus.rd           = main_dec_q.rd;
    assign bus.rs1          = main_dec_q.rs1;
    assign bus.rs2          = main_dec_q.rs2;
    assign bus.imm          = main_dec_q.imm;
    assign bus.zimm         = main_dec_q.zimm;
    assign bus.shift_la_sel = main_dec_q.shift_la_sel;
    assign bus.pred_succ    = main_dec_q.pred_succ;
    assign bus.sys_op       = main_dec_q.sys_op;
    assign bus.trap         = main_dec_q.trap;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: self-checking bench for rv_decode_stage.
//   Two DUTs share stimulus: one with M/Zicsr enabled, one with both disabled.
//   A depth-2 FIFO of expected bundles (from a spec-level decode function)
//   is compared against both DUTs every cycle on the falling edge.
module tb_rv_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  zimm;
        logic        sla;
        logic [7:0]  ps;
        logic [1:0]  sys;
        logic        trap;
    } exp_t;

    typedef struct packed {
        exp_t f;
        exp_t n;
    } pair_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic [4:0]  zimm;
        logic        sla;
        logic [1:0]  sys;
        logic        trap;
        logic        trap_red;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_tests = 0;
    int   n_fail  = 0;
    pair_t q[$];

    rv_decode_stage_if #(.PC_W(32)) ifc ();
    rv_decode_stage_if #(.PC_W(32)) ifc_n ();

    assign ifc_n.in_valid  = ifc.in_valid;
    assign ifc_n.in_pc     = ifc.in_pc;
    assign ifc_n.in_instr  = ifc.in_instr;
    assign ifc_n.out_ready = ifc.out_ready;

    rv_decode_stage #(.ENABLE_M(1'b1), .ENABLE_ZICSR(1'b1), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifc.slave));
    rv_decode_stage #(.ENABLE_M(1'b0), .ENABLE_ZICSR(1'b0), .PC_W(32)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifc_n.slave));

    exp_t got_f, got_n;
    assign got_f = {ifc.pc, ifc.opcode, ifc.funct3, ifc.funct7, ifc.rd, ifc.rs1, ifc.rs2,
                    ifc.imm, ifc.zimm, ifc.shift_la_sel, ifc.pred_succ, ifc.sys_op, ifc.trap};
    assign got_n = {ifc_n.pc, ifc_n.opcode, ifc_n.funct3, ifc_n.funct7, ifc_n.rd, ifc_n.rs1, ifc_n.rs2,
                    ifc_n.imm, ifc_n.zimm, ifc_n.shift_la_sel, ifc_n.pred_succ, ifc_n.sys_op, ifc_n.trap};

    always #5 clk = ~clk;

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference decode written from the format/legality rules.
    function automatic exp_t model(logic [31:0] pcv, logic [31:0] i, bit en_m, bit en_z);
        exp_t e;
        byte fmt;
        bit ok;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [7:0] m;
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        e = '0; e.pc = pcv; e.opcode = i[6:0];
        f3 = i[14:12]; f7 = i[31:25]; ok = 1'b1; fmt = "R"; m = 8'hFF;
        case (i[6:0])
            7'h37, 7'h17: fmt = "U";
            7'h6f: fmt = "J";
            7'h67: begin fmt = "I"; m = 8'h01; ok = m[f3]; end
            7'h63: begin fmt = "B"; m = 8'hF3; ok = m[f3]; end
            7'h03: begin fmt = "I"; m = 8'h37; ok = m[f3]; end
            7'h23: begin fmt = "S"; m = 8'h07; ok = m[f3]; end
            7'h13: begin
                fmt = "I";
                if (f3 == 3'd1 || f3 == 3'd5) e.f7 = f7;
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                e.sla = (f3 == 3'd5) && (f7 == 7'h20);
            end
            7'h33: begin
                fmt = "R"; e.f7 = f7;
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && en_m);
                e.sla = (f7 == 7'h20);
            end
            7'h0f: begin fmt = "I"; e.ps = i[27:20]; end
            7'h73: begin
                if (f3 == 3'd0) begin
                    fmt = "N";
                    if (i == 32'h0000_0073) e.sys = 2'b01;
                    else if (i == 32'h0010_0073) e.sys = 2'b10;
                    else ok = 1'b0;
                end else if (f3 == 3'd4) begin
                    ok = 1'b0;
                end else begin
                    fmt = "C"; ok = en_z;
                end
            end
            default: ok = 1'b0;
        endcase
        e.trap = !ok;
        e.f3   = (fmt == "U" || fmt == "J") ? 3'd0 : f3;
        e.rd   = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J" || fmt == "C") ? i[11:7] : 5'd0;
        e.rs1  = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B" || (fmt == "C" && !f3[2])) ? i[19:15] : 5'd0;
        e.zimm = (fmt == "C" && f3[2]) ? i[19:15] : 5'd0;
        e.rs2  = (fmt == "R" || fmt == "S" || fmt == "B") ? i[24:20] : 5'd0;
        case (fmt)
            "I": begin s12 = i[31:20]; e.imm = 32'(s12); end
            "S": begin s12 = {i[31:25], i[11:7]}; e.imm = 32'(s12); end
            "B": begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; e.imm = 32'(s13); end
            "J": begin s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; e.imm = 32'(s21); end
            "U": e.imm = {i[31:12], 12'h000};
            "C": e.imm = {20'h00000, i[31:20]};
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    task automatic cmp(string tag, exp_t g, exp_t e);
        chk({tag, " trap"}, g.trap, e.trap);
        chk({tag, " pc"}, g.pc, e.pc);
        chk({tag, " opcode"}, g.opcode, e.opcode);
        chk({tag, " funct3"}, g.f3, e.f3);
        if (!e.trap) begin
            chk({tag, " fields"}, {g.f7, g.rd, g.rs1, g.rs2, g.zimm, g.sla, g.ps, g.sys},
                                  {e.f7, e.rd, e.rs1, e.rs2, e.zimm, e.sla, e.ps, e.sys});
            chk({tag, " imm"}, g.imm, e.imm);
        end
    endtask

    task automatic check_state(string tag);
        chk({tag, " out_valid"}, ifc.out_valid, q.size() > 0);
        chk({tag, " in_ready"}, ifc.in_ready, q.size() < 2);
        chk({tag, " out_valid_n"}, ifc_n.out_valid, q.size() > 0);
        chk({tag, " in_ready_n"}, ifc_n.in_ready, q.size() < 2);
        if (q.size() > 0) begin
            cmp({tag, " full"}, got_f, q[0].f);
            cmp({tag, " reduced"}, got_n, q[0].n);
        end
    endtask

    // One clock: model update at the rising edge, check on the falling edge.
    task automatic step(string tag);
        bit acc, con;
        pair_t p;
        acc = ifc.in_valid && (q.size() < 2);
        con = (q.size() > 0) && ifc.out_ready;
        p.f = model(ifc.in_pc, ifc.in_instr, 1'b1, 1'b1);
        p.n = model(ifc.in_pc, ifc.in_instr, 1'b0, 1'b0);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(p);
        end
        @(negedge clk);
        check_state(tag);
    endtask

    vec_t vt[11];
    logic [6:0] opcs[11];
    logic [6:0] f7s[3];
    logic [31:0] got_pc[$];
    logic [31:0] r;
    logic [31:0] gp;
    int c_acc;

    initial begin
        vt[0]  = '{32'h4d228213, 32'h000004d2, 5'd4,  5'd5, 3'd0, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0};
        vt[1]  = '{32'hfe001ee3, 32'hfffffffc, 5'd0,  5'd0, 3'd1, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0};
        vt[2]  = '{32'habcde237, 32'habcde000, 5'd4,  5'd0, 3'd0, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0};
        vt[3]  = '{32'ha5a5a5a5, 32'h00000000, 5'd0,  5'd0, 3'd0, 5'd0,  1'b0, 2'b00, 1'b1, 1'b1};
        vt[4]  = '{32'h4042d1b3, 32'h00000000, 5'd3,  5'd5, 3'd5, 5'd0,  1'b1, 2'b00, 1'b0, 1'b0};
        vt[5]  = '{32'h02b50533, 32'h00000000, 5'd10, 5'd10, 3'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1};
        vt[6]  = '{32'h00100073, 32'h00000000, 5'd0,  5'd0, 3'd0, 5'd0,  1'b0, 2'b10, 1'b0, 1'b0};
        vt[7]  = '{32'h00000073, 32'h00000000, 5'd0,  5'd0, 3'd0, 5'd0,  1'b0, 2'b01, 1'b0, 1'b0};
        vt[8]  = '{32'hfff55ef3, 32'h00000fff, 5'd29, 5'd0, 3'd5, 5'd10, 1'b0, 2'b00, 1'b0, 1'b1};
        vt[9]  = '{32'h00100074, 32'h00000000, 5'd0,  5'd0, 3'd0, 5'd0,  1'b0, 2'b00, 1'b1, 1'b1};
        vt[10] = '{32'h00003063, 32'h00000000, 5'd0,  5'd0, 3'd3, 5'd0,  1'b0, 2'b00, 1'b1, 1'b1};
        opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        f7s  = '{7'h00, 7'h20, 7'h01};

        rst_n = 1'b0; flush = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_pc = 32'd0; ifc.in_instr = 32'd0; ifc.out_ready = 1'b1;
        #1;
        chk("reset out_valid", ifc.out_valid, 1'b0);
        chk("reset in_ready", ifc.in_ready, 1'b1);
        chk("reset bundle", got_f, '0);
        chk("reset bundle_n", got_n, '0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one at a time with out_ready high.
        for (int k = 0; k < 11; k++) begin
            ifc.in_valid = 1'b1; ifc.in_pc = 32'h1000 + 32'(k * 4); ifc.in_instr = vt[k].instr;
            step("vec");
            ifc.in_valid = 1'b0;
            chk($sformatf("vec%0d trap", k), ifc.trap, vt[k].trap);
            chk($sformatf("vec%0d trap_n", k), ifc_n.trap, vt[k].trap_red);
            if (!vt[k].trap) begin
                chk($sformatf("vec%0d imm", k), ifc.imm, vt[k].imm);
                chk($sformatf("vec%0d regs", k), {ifc.rd, ifc.rs1, ifc.funct3}, {vt[k].rd, vt[k].rs1, vt[k].f3});
                chk($sformatf("vec%0d misc", k), {ifc.zimm, ifc.shift_la_sel, ifc.sys_op},
                                                 {vt[k].zimm, vt[k].sla, vt[k].sys});
            end
        end
        step("vec drain");

        // Backpressure: A and B accepted, C stalls; then all three in order.
        ifc.out_ready = 1'b0; ifc.in_valid = 1'b1;
        ifc.in_pc = 32'h100; ifc.in_instr = 32'h00108093; step("bp A");
        ifc.in_pc = 32'h104; ifc.in_instr = 32'h00210113; step("bp B");
        ifc.in_pc = 32'h108; ifc.in_instr = 32'h00318193;
        chk("bp in_ready low", ifc.in_ready, 1'b0);
        step("bp C wait");
        chk("bp hold pc", ifc.pc, 32'h100);
        chk("bp still stalled", ifc.in_ready, 1'b0);
        ifc.out_ready = 1'b1; c_acc = 0;
        for (int k = 0; k < 10; k++) begin
            if (ifc.out_valid) got_pc.push_back(ifc.pc);
            if (ifc.in_valid && ifc.in_ready) begin
                step("bp drain"); ifc.in_valid = 1'b0; c_acc++;
            end else begin
                step("bp drain");
            end
        end
        chk("bp C accepted once", c_acc, 1);
        chk("bp count", got_pc.size(), 3);
        for (int k = 0; k < 3; k++) begin
            gp = (k < got_pc.size()) ? got_pc[k] : 32'hdeadbeef;
            chk($sformatf("bp order%0d", k), gp, 32'h100 + 32'(k * 4));
        end

        // Flush with both entries full and an offer pending.
        ifc.out_ready = 1'b0; ifc.in_valid = 1'b1;
        ifc.in_pc = 32'h300; ifc.in_instr = 32'h00108093; step("fl A");
        ifc.in_pc = 32'h304; step("fl B");
        ifc.in_pc = 32'h308; flush = 1'b1; step("fl pulse");
        flush = 1'b0; ifc.in_valid = 1'b0;
        chk("flush out_valid", ifc.out_valid, 1'b0);
        chk("flush in_ready", ifc.in_ready, 1'b1);
        ifc.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("fl after");
            chk("flush nothing emerges", ifc.out_valid, 1'b0);
        end

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            r = $urandom;
            case ($urandom_range(0, 15))
                0, 1, 2: r = r;
                12: r = 32'h0000_0073;
                13: r = 32'h0010_0073;
                default: begin
                    r[6:0] = opcs[$urandom_range(0, 10)];
                    if ((r[6:0] == 7'h33 || r[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
                        r[31:25] = f7s[$urandom_range(0, 2)];
                end
            endcase
            ifc.in_instr  = r;
            ifc.in_pc     = $urandom;
            ifc.in_valid  = ($urandom_range(0, 3) != 0);
            ifc.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 40) == 0);
            step("rand");
        end
        flush = 1'b0;

        // Asynchronous reset while an entry is valid.
        ifc.out_ready = 1'b0; ifc.in_valid = 1'b1;
        ifc.in_pc = 32'h500; ifc.in_instr = 32'h00108093; step("rst fill");
        ifc.in_valid = 1'b0;
        chk("rst pre out_valid", ifc.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("rst async out_valid", ifc.out_valid, 1'b0);
        chk("rst async in_ready", ifc.in_ready, 1'b1);
        chk("rst async bundle", got_f, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1; ifc.in_valid = 1'b1;
        ifc.in_pc = 32'h600; ifc.in_instr = 32'h004000ef; step("rst jal");
        ifc.in_valid = 1'b0;
        chk("rst jal imm", ifc.imm, 32'h00000004);
        chk("rst jal rd", ifc.rd, 5'd1);
        step("rst end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
